// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t : FSM state encodings (ST_IDLE, ST_CMP)
//   res_t   : result vector {lt, eq, gt}; RES_* are the legal codes
//   res_of  : maps a chunk's lt/gt outcome onto a result code
package cmp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_GT   = 3'b001;

  function automatic res_t res_of(input logic lt, input logic gt);
    if (lt)      return RES_LT;
    else if (gt) return RES_GT;
    else         return RES_EQ;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/result bundle of seq_mag_comparator.
//   start   : compare request
//   A, B    : operands, WIDTH bits
//   busy    : compare in progress
//   done    : one-cycle pulse when L/E/G update
//   L, E, G : A<B, A==B, A>B, held until the next done
// The master drives start/A/B; the slave (the comparator) drives the rest.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             L;
  logic             E;
  logic             G;

  modport master (
    output start, A, B,
    input  busy, done, L, E, G
  );

  modport slave (
    input  start, A, B,
    output busy, done, L, E, G
  );

endinterface

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude comparator.
//   a, b   : CHUNK-bit slices to compare
//   lt     : a < b
//   eq     : a == b
//   gt     : a > b
// Exactly one output is high for any input pair.
module cmp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, and reports L/E/G on registered outputs.
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_mag_comparator_if.slave (start, A, B in; busy, done, L, E, G out)
//
// Parameters
//   WIDTH  : operand width, integer multiple of CHUNK
//   CHUNK  : bits compared per cycle, 1..WIDTH
//   SIGNED : 0 = unsigned, 1 = two's-complement compare
//
// Build option
//   CMP_EARLY_EXIT_EN : when defined, the compare finishes on the first
//                       differing chunk instead of always walking NCHUNK chunks.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; L/E/G hold the last result
// ST_CMP  | one chunk per cycle from the shift registers; busy=1
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CHUNK  = 2,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_mag_comparator_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  // Flipping both MSBs maps two's-complement ordering onto unsigned ordering.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;
  res_t             dec_res;
  res_t             res;
  logic             done_q;

  logic             c_lt;
  logic             c_eq;
  logic             c_gt;
  res_t             chunk_res;
  res_t             final_res;
  logic             last_chunk;
  logic             exit_now;

  logic             load;
  logic             step;
  logic             finish;

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (sh_a[WIDTH-1 -: CHUNK]),
    .b  (sh_b[WIDTH-1 -: CHUNK]),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  assign chunk_res  = res_of(c_lt, c_gt);
  assign last_chunk = (cnt == CW'(1));

  // An earlier differing chunk always wins; otherwise the current chunk
  // decides, and equality falls out when no chunk ever differed.
  assign final_res  = decided ? dec_res : chunk_res;

`ifdef CMP_EARLY_EXIT_EN
  assign exit_now = last_chunk || (!decided && !c_eq);
`else
  assign exit_now = last_chunk;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = ST_CMP;
        end
      end
      ST_CMP: begin
        step = 1'b1;
        if (exit_now) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_res <= RES_NONE;
      res     <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        sh_a    <= bus.A ^ SIGN_MASK;
        sh_b    <= bus.B ^ SIGN_MASK;
        cnt     <= CW'(NCHUNK);
        decided <= 1'b0;
        dec_res <= RES_NONE;
      end else if (step) begin
        sh_a <= sh_a << CHUNK;
        sh_b <= sh_b << CHUNK;
        cnt  <= cnt - CW'(1);
        if (!decided && !c_eq) begin
          decided <= 1'b1;
          dec_res <= chunk_res;
        end
      end
      if (finish) begin
        res <= final_res;
      end
    end
  end

  // busy decodes the state flop directly, so it is still a registered output.
  assign bus.busy = (state == ST_CMP);
  assign bus.done = done_q;
  assign bus.L    = res[2];
  assign bus.E    = res[1];
  assign bus.G    = res[0];

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, multi-cycle magnitude comparator that evaluates two WIDTH-bit operands MSB-first, CHUNK bits per clock, and reports less/equal/greater on registered outputs with a start/busy/done handshake. It is the sequential, width-generic successor to the team's 2-bit combinational L/E/G comparator. It sits beside datapath blocks that need wide compares without a long combinational carry chain.

## Interface
- WIDTH, 8, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- A  input  WIDTH  operand A; sampled only on acceptance.
- B  input  WIDTH  operand B; sampled only on acceptance.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when L/E/G update.
- L  output  1  A<B; held until the next done.
- E  output  1  A==B; held until the next done.
- G  output  1  A>B; held until the next done.

## Operation
- NCHUNK = WIDTH/CHUNK. FSM states: IDLE and CMP.
- IDLE: on start=1, the block latches A and B into shift registers, sets busy=1, clears the decided flag, loads the chunk counter with NCHUNK, and enters CMP.
- Signed mode: the MSB of both latched operands is inverted at capture, so the compare proceeds as unsigned.
- CMP, each cycle:
  - Compares the top CHUNK bits of the two shift registers.
  - If the decided flag is clear and the chunks differ, records lt/gt and sets the decided flag. Later chunks never override a decided result.
  - Shifts both registers left by CHUNK and decrements the counter.
- Completion (without early exit): on the cycle that processes the last chunk, the block registers L/E/G, pulses done, clears busy, and returns to IDLE.
  - E=1 only if no chunk differed.
  - Exactly one of L/E/G is 1 after the first done.
- start while busy=1 is ignored. It is not queued.
- start in the done cycle is accepted (busy=0 then), giving back-to-back operation.
- Reset mid-operation aborts the compare; no done is produced.

## Timing
- Reset values: busy=0, done=0, L=0, E=0, G=0, state IDLE.
- start is sampled at edge k; busy is high from edge k.
- done and the new L/E/G appear after edge k+NCHUNK (latency NCHUNK cycles) when CMP_EARLY_EXIT_EN is undefined.
- Throughput: one compare per NCHUNK cycles.
- NCHUNK=1: done after edge k+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- CMP_EARLY_EXIT_EN defined:
  - CMP exits on the first differing chunk j (1 = MSB chunk) and asserts done after edge k+j.
  - Equal operands still take NCHUNK cycles.
- CMP_EARLY_EXIT_EN undefined: latency is fixed at NCHUNK regardless of data.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package cmp_pkg holds:
  - state encodings ST_IDLE and ST_CMP;
  - the result encoding constants for lt/eq/gt.
- Sub-module cmp_chunk: combinational CHUNK-bit comparator with outputs lt, eq, gt. It is instantiated once on the top chunk of the shift registers.
- Top level holds the FSM, shift registers, counter, decided flag and output registers.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 unless noted.

- A=8'h5A, B=8'h5A, start -> done after 4 cycles, E=1, L=G=0, in both builds.
- A=8'h80, B=8'h7F:
  - SIGNED=0 -> G=1.
  - SIGNED=1 -> L=1.
  - With CMP_EARLY_EXIT_EN, done arrives 1 cycle after start.
- A=8'h13, B=8'h12 -> G=1, done after 4 cycles in both builds (difference is in the last chunk).
- Handshake sequence:
  - start A=8'h01, B=8'h02.
  - Pulse start with A=8'hFF mid-compare -> ignored.
  - Assert start in the done cycle with A=8'h02, B=8'h01 -> first result L=1, second result G=1 exactly 4 cycles later.
- Assert rst_n=0 at cycle 2 of a compare -> busy, done, L, E, G all 0 immediately; no done follows until a new start.
- WIDTH=2, CHUNK=2, exhaustive 16 operand pairs x SIGNED∈{0,1} -> L/E/G match a reference model, done 1 cycle after each start.
